axi_line_master: RTL and testbench
==================================

# axi_line_master

Single-outstanding AXI4 burst master that turns cache-line refill/writeback requests into INCR bursts. It sits directly upstream of the AXI4 RAM slave (`axi_ram`) on the data-memory path, replacing ad-hoc test stimulus. It buffers one full line and returns refill data as one wide word. It holds at most one transaction in flight and does no reordering.

## Interface
Parameters:
- DATA_WIDTH, 32, AXI data width in bits; power of two, at least 8.
- ADDR_WIDTH, 32, AXI and request address width.
- ID_WIDTH, 4, AXI ID width.
- AXI_ID, 0, constant value driven on awid/arid.
- LINE_WORDS, 8, beats per line; power of two, 1 to 256.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  reset, asynchronous assert, active-low.
- req_valid  in  1  request valid.
- req_ready  out  1  request accepted when high with req_valid.
- req_write  in  1  1 = writeback, 0 = refill.
- req_addr  in  ADDR_WIDTH  line address; low offset bits ignored.
- req_wdata  in  LINE_WORDS*DATA_WIDTH  writeback line; word 0 in the LSBs.
- resp_valid  out  1  completion valid.
- resp_ready  in  1  completion accepted.
- resp_rdata  out  LINE_WORDS*DATA_WIDTH  refill line; zero-held for writes.
- resp_err  out  1  error flag (see Configuration).
- m_axi_aw*/w*/b*/ar*/r*: full AXI4 master set matching the RAM slave ports. Widths: id ID_WIDTH, addr ADDR_WIDTH, data DATA_WIDTH, strb DATA_WIDTH/8.

## Operation
- States: IDLE, AR, R, AW, W, B, RESP.
- IDLE: req_ready=1. On req_valid, latch the request and go to AR (read) or AW (write). For a write, also latch req_wdata into the line buffer.
- Address: addr & ~(LINE_WORDS*DATA_WIDTH/8 - 1).
- Constant AXI fields:
  - len = LINE_WORDS-1.
  - size = log2(DATA_WIDTH/8).
  - burst = 2'b01.
  - lock, cache, prot = 0.
  - wstrb all ones.
- AR: arvalid=1 until arready, then go to R.
- R: rready=1. Each rvalid beat stores rdata at buffer[beat]; beat increments.
  - After beat LINE_WORDS-1 is accepted, go to RESP.
  - The beat counter is authoritative; rlast is not used for sequencing.
- AW: awvalid=1 until awready, then go to W. W is entered only after AW is accepted, because the slave requires this order.
- W: wvalid=1; wdata=buffer[beat]; wlast=(beat==LINE_WORDS-1); beat advances on wready. After the last beat, go to B.
- B: bready=1. On bvalid, go to RESP.
- RESP: resp_valid=1 and resp_rdata=buffer. Hold until resp_ready, then go to IDLE.
- Beat counter: 8 bits, cleared on entry to R and to W.
- Outputs driven outside their state: all 0.

## Timing
- Reset (rst=0): state IDLE; all valid/ready outputs 0 except req_ready=1; resp_rdata=0; resp_err=0; beat=0. Reset takes effect immediately, mid-burst included, and abandons the AXI transaction. The slave must be reset together with the master.
- All AXI and resp outputs are registered or decoded from the state register; no combinational path from inputs to outputs.
- Request accepted in cycle 0 → arvalid/awvalid high in cycle 1.
- With a zero-wait slave, read resp_valid follows the last R beat by 1 cycle.
- Write: AW handshake, then LINE_WORDS W beats, one per cycle when wready=1, then B, then resp_valid one cycle after the bvalid handshake.
- Back-to-back requests: req_ready returns the cycle after the resp handshake. No request is accepted while resp_valid=1.
- Stalls: valid stays asserted and the payload stays stable under any slave stall, per AXI rules.
- LINE_WORDS=1: single beat, wlast=1 on the first beat, len=0.

## Configuration
- AXI_LINE_MASTER_ERR_CHECK_EN defined:
  - resp_err is sticky per transaction and cleared on request accept.
  - It sets if any rresp/bresp != 2'b00, or if rlast mismatches (beat==LINE_WORDS-1).
  - It is valid with resp_valid.
- Undefined: resp_err is tied to 0; rresp, bresp and rlast are ignored.

## Test plan
- Refill: RAM word i at 0x100 preloaded with 0xA0+i; request read at addr 0x10C → araddr 0x100, arlen 7, resp_rdata word i = 0xA0+i, resp_err=0.
- Writeback then refill: write line word i = 0x5500+i at 0x200, bresp OKAY → resp_valid; read 0x200 returns the same line.
- Backpressure: hold resp_ready=0 for 5 cycles → resp_valid and resp_rdata stable, req_ready=0; accept → req_ready=1 the next cycle.
- Slave stall: insert random rvalid/wready gaps → all 8 beats are correct and wlast is only on beat 7.
- Reset mid-burst: assert rst after the 3rd R beat → all AXI valids and resp_valid are 0 immediately and req_ready=1. A refill after reset is correct.
- With macro: force rresp=2'b10 on beat 2 → resp_err=1. Without the macro, the same stimulus gives resp_err=0.

Source files
------------

// File: rtl/axi_line_master.sv
// Cache-line AXI4 master: one INCR read (refill) or INCR write (writeback) burst in flight.
// Latency: request accept -> a*valid next cycle; resp_valid one cycle after last R / B handshake.
// Backpressure: waits on every AXI ready; no new request accepted until the resp handshake.
//
// Ports: clk, rst (async, active-low); req_* line request in (req_wdata word 0 in LSBs);
// resp_* completion out (resp_rdata zero for writebacks); m_axi_* full AXI4 master (aw/w/b/ar/r).
// Optional feature: define AXI_LINE_MASTER_ERR_CHECK_EN to flag rresp/bresp/rlast errors on resp_err.
module axi_line_master #(
    parameter int          DATA_WIDTH = 32,
    parameter int          ADDR_WIDTH = 32,
    parameter int          ID_WIDTH   = 4,
    parameter int unsigned AXI_ID     = 0,
    parameter int          LINE_WORDS = 8
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             req_valid,
    output logic                             req_ready,
    input  logic                             req_write,
    input  logic [ADDR_WIDTH-1:0]            req_addr,
    input  logic [LINE_WORDS*DATA_WIDTH-1:0] req_wdata,
    output logic                             resp_valid,
    input  logic                             resp_ready,
    output logic [LINE_WORDS*DATA_WIDTH-1:0] resp_rdata,
    output logic                             resp_err,
    output logic [ID_WIDTH-1:0]              m_axi_awid,
    output logic [ADDR_WIDTH-1:0]            m_axi_awaddr,
    output logic [7:0]                       m_axi_awlen,
    output logic [2:0]                       m_axi_awsize,
    output logic [1:0]                       m_axi_awburst,
    output logic                             m_axi_awlock,
    output logic [3:0]                       m_axi_awcache,
    output logic [2:0]                       m_axi_awprot,
    output logic                             m_axi_awvalid,
    input  logic                             m_axi_awready,
    output logic [DATA_WIDTH-1:0]            m_axi_wdata,
    output logic [DATA_WIDTH/8-1:0]          m_axi_wstrb,
    output logic                             m_axi_wlast,
    output logic                             m_axi_wvalid,
    input  logic                             m_axi_wready,
    input  logic [ID_WIDTH-1:0]              m_axi_bid,
    input  logic [1:0]                       m_axi_bresp,
    input  logic                             m_axi_bvalid,
    output logic                             m_axi_bready,
    output logic [ID_WIDTH-1:0]              m_axi_arid,
    output logic [ADDR_WIDTH-1:0]            m_axi_araddr,
    output logic [7:0]                       m_axi_arlen,
    output logic [2:0]                       m_axi_arsize,
    output logic [1:0]                       m_axi_arburst,
    output logic                             m_axi_arlock,
    output logic [3:0]                       m_axi_arcache,
    output logic [2:0]                       m_axi_arprot,
    output logic                             m_axi_arvalid,
    input  logic                             m_axi_arready,
    input  logic [ID_WIDTH-1:0]              m_axi_rid,
    input  logic [DATA_WIDTH-1:0]            m_axi_rdata,
    input  logic [1:0]                       m_axi_rresp,
    input  logic                             m_axi_rlast,
    input  logic                             m_axi_rvalid,
    output logic                             m_axi_rready
);

    localparam int                    LINE_BITS  = LINE_WORDS * DATA_WIDTH;
    localparam int                    STRB_WIDTH = DATA_WIDTH / 8;
    localparam logic [ADDR_WIDTH-1:0] LINE_MASK  = ADDR_WIDTH'(LINE_WORDS * STRB_WIDTH - 1);
    localparam logic [7:0]            LAST_BEAT  = 8'(LINE_WORDS - 1);
    localparam logic [2:0]            AXI_SIZE   = 3'($clog2(STRB_WIDTH));

    typedef enum logic [2:0] {
        S_IDLE, S_AR, S_R, S_AW, S_W, S_B, S_RESP
    } state_t;

    state_t                  state_q, state_d;
    logic [7:0]              beat_q, beat_d;
    logic [LINE_BITS-1:0]    line_q, line_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic                    write_q, write_d;

    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        line_d  = line_q;
        addr_d  = addr_q;
        write_d = write_q;
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    addr_d  = req_addr & ~LINE_MASK;
                    write_d = req_write;
                    if (req_write) begin
                        line_d  = req_wdata;
                        state_d = S_AW;
                    end else begin
                        state_d = S_AR;
                    end
                end
            end
            S_AR: begin
                if (m_axi_arready) begin
                    beat_d  = '0;
                    state_d = S_R;
                end
            end
            S_R: begin
                // Sequencing follows the local beat count; rlast only feeds the error check.
                if (m_axi_rvalid) begin
                    line_d[beat_q * DATA_WIDTH +: DATA_WIDTH] = m_axi_rdata;
                    beat_d = beat_q + 8'd1;
                    if (beat_q == LAST_BEAT) state_d = S_RESP;
                end
            end
            S_AW: begin
                // W only starts after AW is accepted; the downstream RAM needs that order.
                if (m_axi_awready) begin
                    beat_d  = '0;
                    state_d = S_W;
                end
            end
            S_W: begin
                if (m_axi_wready) begin
                    beat_d = beat_q + 8'd1;
                    if (beat_q == LAST_BEAT) state_d = S_B;
                end
            end
            S_B: begin
                if (m_axi_bvalid) state_d = S_RESP;
            end
            S_RESP: begin
                if (resp_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            beat_q  <= '0;
            line_q  <= '0;
            addr_q  <= '0;
            write_q <= 1'b0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            line_q  <= line_d;
            addr_q  <= addr_d;
            write_q <= write_d;
        end
    end

    // Every output is a decode of registered state, so no input reaches an output combinationally.
    assign req_ready     = (state_q == S_IDLE);
    assign resp_valid    = (state_q == S_RESP);
    assign resp_rdata    = (state_q == S_RESP && !write_q) ? line_q : '0;

    assign m_axi_awid    = ID_WIDTH'(AXI_ID);
    assign m_axi_awaddr  = (state_q == S_AW) ? addr_q : '0;
    assign m_axi_awlen   = LAST_BEAT;
    assign m_axi_awsize  = AXI_SIZE;
    assign m_axi_awburst = 2'b01;
    assign m_axi_awlock  = 1'b0;
    assign m_axi_awcache = 4'd0;
    assign m_axi_awprot  = 3'd0;
    assign m_axi_awvalid = (state_q == S_AW);

    assign m_axi_wdata   = (state_q == S_W) ? line_q[beat_q * DATA_WIDTH +: DATA_WIDTH] : '0;
    assign m_axi_wstrb   = (state_q == S_W) ? '1 : '0;
    assign m_axi_wlast   = (state_q == S_W) && (beat_q == LAST_BEAT);
    assign m_axi_wvalid  = (state_q == S_W);
    assign m_axi_bready  = (state_q == S_B);

    assign m_axi_arid    = ID_WIDTH'(AXI_ID);
    assign m_axi_araddr  = (state_q == S_AR) ? addr_q : '0;
    assign m_axi_arlen   = LAST_BEAT;
    assign m_axi_arsize  = AXI_SIZE;
    assign m_axi_arburst = 2'b01;
    assign m_axi_arlock  = 1'b0;
    assign m_axi_arcache = 4'd0;
    assign m_axi_arprot  = 3'd0;
    assign m_axi_arvalid = (state_q == S_AR);
    assign m_axi_rready  = (state_q == S_R);

`ifdef AXI_LINE_MASTER_ERR_CHECK_EN
    // Sticky for the current transaction; cleared when the next request is taken.
    logic err_q, err_d;

    always_comb begin
        err_d = err_q;
        if (state_q == S_IDLE && req_valid) err_d = 1'b0;
        if (state_q == S_R && m_axi_rvalid &&
            (m_axi_rresp != 2'b00 || m_axi_rlast != (beat_q == LAST_BEAT))) err_d = 1'b1;
        if (state_q == S_B && m_axi_bvalid && m_axi_bresp != 2'b00) err_d = 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) err_q <= 1'b0;
        else      err_q <= err_d;
    end

    assign resp_err = (state_q == S_RESP) && err_q;

    logic unused_ok;
    assign unused_ok = &{1'b0, m_axi_bid, m_axi_rid};
`else
    assign resp_err = 1'b0;

    logic unused_ok;
    assign unused_ok = &{1'b0, m_axi_bid, m_axi_rid, m_axi_rresp, m_axi_bresp, m_axi_rlast};
`endif

endmodule

// File: tb/tb_axi_line_master.sv
// Bench for axi_line_master: directed + randomized line requests against a small AXI RAM responder.
// Expected lines come from a word-array model of memory updated per request.
// Responder can insert random ready/valid gaps and inject an rresp error on a chosen beat.
module tb_axi_line_master;
    localparam int DW         = 32;
    localparam int AW         = 32;
    localparam int IW         = 4;
    localparam int LW         = 8;
    localparam int LB         = LW * DW;
    localparam int LINE_BYTES = LW * DW / 8;
    typedef logic [LB-1:0] vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic          req_valid, req_ready, req_write;
    logic [AW-1:0] req_addr;
    vec_t          req_wdata, resp_rdata;
    logic          resp_valid, resp_ready, resp_err;
    logic [IW-1:0] awid, arid, bid, rid;
    logic [AW-1:0] awaddr, araddr;
    logic [7:0]    awlen, arlen;
    logic [2:0]    awsize, arsize, awprot, arprot;
    logic [1:0]    awburst, arburst, bresp, rresp;
    logic          awlock, arlock, awvalid, awready, arvalid, arready;
    logic [3:0]    awcache, arcache;
    logic [DW-1:0] wdata, rdata;
    logic [DW/8-1:0] wstrb;
    logic          wlast, wvalid, wready, bvalid, bready, rlast, rvalid, rready;

    axi_line_master dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .m_axi_awid(awid), .m_axi_awaddr(awaddr), .m_axi_awlen(awlen), .m_axi_awsize(awsize),
        .m_axi_awburst(awburst), .m_axi_awlock(awlock), .m_axi_awcache(awcache), .m_axi_awprot(awprot),
        .m_axi_awvalid(awvalid), .m_axi_awready(awready),
        .m_axi_wdata(wdata), .m_axi_wstrb(wstrb), .m_axi_wlast(wlast), .m_axi_wvalid(wvalid),
        .m_axi_wready(wready),
        .m_axi_bid(bid), .m_axi_bresp(bresp), .m_axi_bvalid(bvalid), .m_axi_bready(bready),
        .m_axi_arid(arid), .m_axi_araddr(araddr), .m_axi_arlen(arlen), .m_axi_arsize(arsize),
        .m_axi_arburst(arburst), .m_axi_arlock(arlock), .m_axi_arcache(arcache), .m_axi_arprot(arprot),
        .m_axi_arvalid(arvalid), .m_axi_arready(arready),
        .m_axi_rid(rid), .m_axi_rdata(rdata), .m_axi_rresp(rresp), .m_axi_rlast(rlast),
        .m_axi_rvalid(rvalid), .m_axi_rready(rready)
    );

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- AXI RAM responder ----------------
    logic [31:0] mem [0:1023];
    logic [31:0] ref_mem [0:255];
    bit          stall_en = 1'b0;
    bit          err_en   = 1'b0;
    logic [9:0]  err_beat = '0;
    logic        pre_en   = 1'b0;
    logic [9:0]  pre_idx  = '0;
    logic [31:0] pre_dat  = '0;
    logic [9:0]  r_word, r_idx, w_word, r_nidx;
    logic [8:0]  r_left, r_nleft;
    logic [7:0]  w_idx, w_len;
    logic        r_hs;
    int w_bad = 0, w_beats = 0, r_hs_cnt = 0, last_r_cyc = 0, last_b_cyc = 0, stab_bad = 0;

    assign bid    = '0;
    assign rid    = '0;
    assign bresp  = 2'b00;
    assign r_hs   = rvalid && rready;
    assign r_nidx = r_idx + 10'(r_hs);
    assign r_nleft = r_left - 9'(r_hs);

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            arready <= 1'b0; awready <= 1'b0; wready <= 1'b0; bvalid <= 1'b0;
            rvalid <= 1'b0; rlast <= 1'b0; rdata <= '0; rresp <= 2'b00;
            r_word <= '0; r_idx <= '0; r_left <= '0; w_word <= '0; w_idx <= '0; w_len <= '0;
        end else begin
            if (pre_en) mem[pre_idx] <= pre_dat;
            arready <= !stall_en || ($urandom_range(0, 2) != 0);
            awready <= !stall_en || ($urandom_range(0, 2) != 0);
            wready  <= !stall_en || ($urandom_range(0, 2) != 0);
            if (arvalid && arready) begin
                r_word <= araddr[11:2];
                r_idx  <= '0;
                r_left <= 9'(arlen) + 9'd1;
            end else begin
                if (r_hs) begin
                    r_hs_cnt <= r_hs_cnt + 1;
                    if (r_nleft == 9'd0) last_r_cyc <= cyc;
                end
                if (!rvalid || r_hs) begin
                    if (r_nleft != 9'd0 && (!stall_en || $urandom_range(0, 2) != 0)) begin
                        rvalid <= 1'b1;
                        rdata  <= mem[r_word + r_nidx];
                        rlast  <= (r_nleft == 9'd1);
                        rresp  <= (err_en && r_nidx == err_beat) ? 2'b10 : 2'b00;
                    end else begin
                        rvalid <= 1'b0;
                    end
                end
                r_idx  <= r_nidx;
                r_left <= r_nleft;
            end
            if (awvalid && awready) begin
                w_word <= awaddr[11:2];
                w_len  <= awlen;
                w_idx  <= '0;
            end
            if (wvalid && wready) begin
                mem[w_word + 10'(w_idx)] <= wdata;
                if (wlast !== (w_idx == w_len)) w_bad <= w_bad + 1;
                w_beats <= w_beats + 1;
                w_idx   <= w_idx + 8'd1;
            end
            if (bvalid && bready) begin
                bvalid     <= 1'b0;
                last_b_cyc <= cyc;
            end else if (wvalid && wready && wlast) begin
                bvalid <= 1'b1;
            end
        end
    end

    // AXI stability watcher: a stalled valid must stay up with an unchanged payload.
    logic          p_ar = 1'b0, p_aw = 1'b0, p_w = 1'b0, p_wlast = 1'b0;
    logic [AW-1:0] p_araddr = '0, p_awaddr = '0;
    logic [DW-1:0] p_wdata = '0;
    always @(posedge clk) begin
        if (!rst) begin
            p_ar <= 1'b0; p_aw <= 1'b0; p_w <= 1'b0;
        end else begin
            if (p_ar && (!arvalid || araddr != p_araddr)) stab_bad <= stab_bad + 1;
            if (p_aw && (!awvalid || awaddr != p_awaddr)) stab_bad <= stab_bad + 1;
            if (p_w && (!wvalid || wdata != p_wdata || wlast != p_wlast)) stab_bad <= stab_bad + 1;
            if (wvalid && wstrb != 4'hF) stab_bad <= stab_bad + 1;
            p_ar <= arvalid && !arready; p_araddr <= araddr;
            p_aw <= awvalid && !awready; p_awaddr <= awaddr;
            p_w  <= wvalid && !wready;   p_wdata  <= wdata; p_wlast <= wlast;
        end
    end

    // ---------------- checking helpers ----------------
    task automatic check(input string tag, input vec_t obs, input vec_t exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic vec_t exp_line(input logic [AW-1:0] a);
        vec_t v;
        int   base;
        base = int'(a / LINE_BYTES) * LW;
        for (int i = 0; i < LW; i++) v[i*DW +: DW] = ref_mem[8'(base + i)];
        return v;
    endfunction

    task automatic model_write(input logic [AW-1:0] a, input vec_t line);
        int base;
        base = int'(a / LINE_BYTES) * LW;
        for (int i = 0; i < LW; i++) ref_mem[8'(base + i)] = line[i*DW +: DW];
    endtask

    task automatic run_req(input logic wr, input logic [AW-1:0] addr, input vec_t wline,
                           input int hold, output vec_t rline, output logic err);
        int            n;
        logic [AW-1:0] base;
        vec_t          held;
        base = addr - (addr % LINE_BYTES);
        @(negedge clk);
        req_valid = 1'b1; req_write = wr; req_addr = addr; req_wdata = wline; resp_ready = 1'b0;
        n = 0;
        while (!req_ready && n < 100) begin @(negedge clk); n++; end
        @(negedge clk);
        req_valid = 1'b0; req_wdata = '0;
        if (wr) begin
            check("aw_cycle1", vec_t'(awvalid), vec_t'(1));
            check("aw_addr", vec_t'(awaddr), vec_t'(base));
            check("aw_const", vec_t'({awid, awlen, awsize, awburst, awlock, awcache, awprot}),
                  vec_t'({4'd0, 8'd7, 3'd2, 2'b01, 1'b0, 4'd0, 3'd0}));
        end else begin
            check("ar_cycle1", vec_t'(arvalid), vec_t'(1));
            check("ar_addr", vec_t'(araddr), vec_t'(base));
            check("ar_const", vec_t'({arid, arlen, arsize, arburst, arlock, arcache, arprot}),
                  vec_t'({4'd0, 8'd7, 3'd2, 2'b01, 1'b0, 4'd0, 3'd0}));
        end
        n = 0;
        while (!resp_valid && n < 2000) begin @(negedge clk); n++; end
        check("resp_seen", vec_t'(resp_valid), vec_t'(1));
        check(wr ? "b_to_resp" : "r_to_resp", vec_t'(cyc - (wr ? last_b_cyc : last_r_cyc)), vec_t'(1));
        rline = resp_rdata;
        err   = resp_err;
        held  = resp_rdata;
        for (int k = 0; k < hold; k++) begin
            @(negedge clk);
            check("hold_state", vec_t'({resp_valid, req_ready, resp_rdata == held}), vec_t'(3'b101));
        end
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
        check("after_resp", vec_t'({resp_valid, req_ready}), vec_t'(2'b01));
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        vec_t        rl, wl;
        logic        er, exp_err;
        int          n, cnt0, beats0;
        logic [AW-1:0] a;
        rst = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0; resp_ready = 1'b0;
        #12;
        check("reset_outputs",
              vec_t'({req_ready, arvalid, awvalid, wvalid, rready, bready, resp_valid, resp_err}),
              vec_t'(8'b1000_0000));
        check("reset_rdata", resp_rdata, vec_t'(0));
        @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < 256; i++) begin
            logic [31:0] d;
            d = (i >= 64 && i < 72) ? 32'hA0 + 32'(i - 64) : $urandom;
            ref_mem[8'(i)] = d;
            pre_idx = 10'(i); pre_dat = d; pre_en = 1'b1;
            @(negedge clk);
        end
        pre_en = 1'b0;

        // Refill of a misaligned address inside the 0x100 line.
        run_req(1'b0, 32'h10C, '0, 0, rl, er);
        check("refill_line", rl, exp_line(32'h100));
        check("refill_word3", vec_t'(rl[3*DW +: DW]), vec_t'(32'hA3));
        check("refill_err", vec_t'(er), vec_t'(0));

        // Writeback then refill of the same line.
        for (int i = 0; i < LW; i++) wl[i*DW +: DW] = 32'h5500 + 32'(i);
        beats0 = w_beats;
        run_req(1'b1, 32'h200, wl, 0, rl, er);
        model_write(32'h200, wl);
        check("wb_rdata_zero", rl, vec_t'(0));
        check("wb_err", vec_t'(er), vec_t'(0));
        check("wb_beats", vec_t'(w_beats - beats0), vec_t'(LW));
        run_req(1'b0, 32'h200, '0, 0, rl, er);
        check("wb_readback", rl, wl);

        // Completion backpressure.
        run_req(1'b0, 32'h100, '0, 5, rl, er);
        check("bp_line", rl, exp_line(32'h100));

        // Random traffic with slave stalls.
        stall_en = 1'b1;
        for (int t = 0; t < 12; t++) begin
            a = AW'($urandom_range(0, 31) * LINE_BYTES + $urandom_range(0, LINE_BYTES - 1));
            if ($urandom_range(0, 1) == 1) begin
                for (int i = 0; i < LW; i++) wl[i*DW +: DW] = $urandom;
                run_req(1'b1, a, wl, 0, rl, er);
                model_write(a, wl);
                check("rand_wr_resp", vec_t'({rl, er}), vec_t'(0));
            end else begin
                run_req(1'b0, a, '0, int'($urandom_range(0, 2)), rl, er);
                check("rand_rd_line", rl, exp_line(a));
            end
        end
        stall_en = 1'b0;
        check("wlast_position", vec_t'(w_bad), vec_t'(0));
        check("stall_stability", vec_t'(stab_bad), vec_t'(0));

        // Error injection on beat 2, then a clean transaction clears the flag.
`ifdef AXI_LINE_MASTER_ERR_CHECK_EN
        exp_err = 1'b1;
`else
        exp_err = 1'b0;
`endif
        err_en = 1'b1; err_beat = 10'd2;
        run_req(1'b0, 32'h140, '0, 0, rl, er);
        err_en = 1'b0;
        check("err_inject", vec_t'(er), vec_t'(exp_err));
        check("err_line", rl, exp_line(32'h140));
        run_req(1'b0, 32'h140, '0, 0, rl, er);
        check("err_cleared", vec_t'(er), vec_t'(0));

        // Reset in the middle of a read burst.
        cnt0 = r_hs_cnt;
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h180;
        @(negedge clk);
        req_valid = 1'b0;
        n = 0;
        while (r_hs_cnt - cnt0 < 3 && n < 200) begin @(negedge clk); n++; end
        check("mid_three_beats", vec_t'(r_hs_cnt - cnt0), vec_t'(3));
        rst = 1'b0;
        #1;
        check("mid_reset_outputs",
              vec_t'({arvalid, awvalid, wvalid, rready, bready, resp_valid, resp_err, req_ready}),
              vec_t'(8'b0000_0001));
        check("mid_reset_rdata", resp_rdata, vec_t'(0));
        @(negedge clk);
        rst = 1'b1;
        run_req(1'b0, 32'h180, '0, 0, rl, er);
        check("post_reset_line", rl, exp_line(32'h180));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish, %0d tests run", tests);
        $fatal(1, "timeout");
    end

endmodule
